// File: rtl/fc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_seq_pkg
// Description : Shared state encodings, default widths and helpers for the
//               frequency-meter measurement sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_seq_pkg;

    // Default widths
    localparam int c_CTR_SIZE  = 32;
    localparam int c_GATE_SIZE = 32;
    localparam int c_TMO_SIZE  = 24;

    // Sequencer state encodings
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ARM  = 3'd1;
    localparam logic [2:0] c_ST_GATE = 3'd2;
    localparam logic [2:0] c_ST_STOP = 3'd3;
    localparam logic [2:0] c_ST_RELS = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

    // States that wait on the counter core and are therefore guarded by the
    // acknowledge timeout
    function automatic logic is_tmo_state(input logic [2:0] st);
        return (st == c_ST_ARM) || (st == c_ST_STOP) || (st == c_ST_RELS);
    endfunction

endpackage : fc_seq_pkg
`default_nettype wire

// File: rtl/fc_seq_tmr.sv
`default_nettype none
// ============================================================================
// Module      : fc_tmr
// Description : Loadable down-counter. o_term is high while the count is 1,
//               i.e. during the last cycle of a window of i_val cycles that
//               starts the cycle after the load.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_tmr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_dec,
    output logic             o_term
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;

    // Load takes priority over counting; the counter parks at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_term = (r_cnt == c_ONE);

endmodule : fc_tmr
`default_nettype wire

// File: rtl/fc_seq.sv
`default_nettype none
// ============================================================================
// Module      : fc_seq
// Description : Autonomous measurement sequencer for the frequency-meter
//               counter core. Latches edge selects, runs the begin/end
//               request handshakes, times the gate window, captures both
//               counters and hands the results to the host via valid/ack.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_seq
    import fc_seq_pkg::*;
#(
    parameter int CTR_SIZE  = c_CTR_SIZE,
    parameter int GATE_SIZE = c_GATE_SIZE,
    parameter int TMO_SIZE  = c_TMO_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 cont,
    input  logic [GATE_SIZE-1:0] gate,
    input  logic [1:0]           bsel,
    input  logic [1:0]           esel,
    output logic [1:0]           bis,
    output logic [1:0]           eis,
    output logic                 brq,
    output logic                 erq,
    input  logic                 bac,
    input  logic                 eac,
    input  logic [CTR_SIZE-1:0]  cta,
    input  logic [CTR_SIZE-1:0]  ctc,
    output logic [CTR_SIZE-1:0]  res_a,
    output logic [CTR_SIZE-1:0]  res_c,
    output logic                 valid,
    input  logic                 ack,
    output logic                 busy,
    output logic                 err
);

    localparam logic [GATE_SIZE-1:0] c_GATE_ONE = {{(GATE_SIZE-1){1'b0}}, 1'b1};

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_timeout;

    logic [1:0]           r_bis;
    logic [1:0]           r_eis;
    logic                 r_cont;
    logic [GATE_SIZE-1:0] r_gate;
    logic [CTR_SIZE-1:0]  r_res_a;
    logic [CTR_SIZE-1:0]  r_res_c;
    logic                 r_brq;
    logic                 r_erq;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_err;

    logic                 w_gate_load;
    logic [GATE_SIZE-1:0] w_gate_val;
    logic                 w_gate_term;
    logic                 w_tmo_load;
    logic                 w_tmo_term;
    logic                 w_tmo_hit;

    // A zero gate time still yields a one-cycle window
    assign w_gate_val  = (r_gate == '0) ? c_GATE_ONE : r_gate;
    assign w_gate_load = (r_state == c_ST_ARM) && (w_next == c_ST_GATE);

    // Timeout restarts whenever a guarded state is entered (including
    // ARM re-entry from DONE in continuous mode)
    assign w_tmo_load = (w_next != r_state) && is_tmo_state(w_next);
    assign w_tmo_hit  = is_tmo_state(r_state) && w_tmo_term;

    fc_tmr #(
        .WIDTH (GATE_SIZE)
    ) u_gate_tmr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_gate_load),
        .i_val  (w_gate_val),
        .i_dec  (r_state == c_ST_GATE),
        .o_term (w_gate_term)
    );

    fc_tmr #(
        .WIDTH (TMO_SIZE)
    ) u_tmo_tmr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmo_load),
        .i_val  ({TMO_SIZE{1'b1}}),
        .i_dec  (is_tmo_state(r_state)),
        .o_term (w_tmo_term)
    );

    // Next-state decode; abort overrides every other event, a completed
    // handshake wins over a coincident timeout
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        if (abort) begin
            w_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        w_next   = c_ST_ARM;
                        w_accept = 1'b1;
                    end
                end
                c_ST_ARM: begin
                    if (bac) begin
                        w_next = c_ST_GATE;
                    end else if (w_tmo_hit) begin
                        w_next    = c_ST_IDLE;
                        w_timeout = 1'b1;
                    end
                end
                c_ST_GATE: begin
                    if (w_gate_term) begin
                        w_next = c_ST_STOP;
                    end
                end
                c_ST_STOP: begin
                    if (eac) begin
                        w_next    = c_ST_RELS;
                        w_capture = 1'b1;
                    end else if (w_tmo_hit) begin
                        w_next    = c_ST_IDLE;
                        w_timeout = 1'b1;
                    end
                end
                c_ST_RELS: begin
                    if (!bac && !eac) begin
                        w_next = c_ST_DONE;
                    end else if (w_tmo_hit) begin
                        w_next    = c_ST_IDLE;
                        w_timeout = 1'b1;
                    end
                end
                c_ST_DONE: begin
                    if (ack) begin
                        w_next = r_cont ? c_ST_ARM : c_ST_IDLE;
                    end
                end
                default: begin
                    w_next = c_ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Measurement setup latched when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bis  <= 2'b00;
            r_eis  <= 2'b00;
            r_cont <= 1'b0;
            r_gate <= '0;
        end else if (w_accept) begin
            r_bis  <= bsel;
            r_eis  <= esel;
            r_cont <= cont;
            r_gate <= gate;
        end
    end

    // Results only move on the end-acknowledge edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_a <= '0;
            r_res_c <= '0;
        end else if (w_capture) begin
            r_res_a <= cta;
            r_res_c <= ctc;
        end
    end

    // Handshake/status outputs registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_brq   <= 1'b0;
            r_erq   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_brq   <= (w_next == c_ST_ARM) || (w_next == c_ST_GATE) || (w_next == c_ST_STOP);
            r_erq   <= (w_next == c_ST_STOP);
            r_valid <= (w_next == c_ST_DONE);
            r_busy  <= (w_next != c_ST_IDLE);
        end
    end

    // Sticky timeout flag, cleared only by an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign bis   = r_bis;
    assign eis   = r_eis;
    assign brq   = r_brq;
    assign erq   = r_erq;
    assign res_a = r_res_a;
    assign res_c = r_res_c;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign err   = r_err;

endmodule : fc_seq
`default_nettype wire

// File: tb/tb_fc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_seq
// Description : Self-checking bench for fc_seq. The stimulus side plays the
//               counter core and host, pushing expected results into a
//               scoreboard; a monitor pops them whenever valid rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_seq;

    localparam int c_CW = 32;
    localparam int c_GW = 32;
    localparam int c_TW = 4;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            cont  = 1'b0;
    logic [c_GW-1:0] gate  = '0;
    logic [1:0]      bsel  = 2'b00;
    logic [1:0]      esel  = 2'b00;
    logic            bac   = 1'b0;
    logic            eac   = 1'b0;
    logic            ack   = 1'b0;
    logic [c_CW-1:0] cta   = '0;
    logic [c_CW-1:0] ctc   = '0;
    logic [1:0]      bis;
    logic [1:0]      eis;
    logic            brq;
    logic            erq;
    logic [c_CW-1:0] res_a;
    logic [c_CW-1:0] res_c;
    logic            valid;
    logic            busy;
    logic            err;

    fc_seq #(
        .CTR_SIZE  (c_CW),
        .GATE_SIZE (c_GW),
        .TMO_SIZE  (c_TW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .cont  (cont),
        .gate  (gate),
        .bsel  (bsel),
        .esel  (esel),
        .bis   (bis),
        .eis   (eis),
        .brq   (brq),
        .erq   (erq),
        .bac   (bac),
        .eac   (eac),
        .cta   (cta),
        .ctc   (ctc),
        .res_a (res_a),
        .res_c (res_c),
        .valid (valid),
        .ack   (ack),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int              n_vec = 0;
    int              n_bad = 0;
    logic [c_CW-1:0] exp_q_a[$];
    logic [c_CW-1:0] exp_q_c[$];
    logic [c_CW-1:0] last_a  = '0;
    logic [c_CW-1:0] last_c  = '0;
    logic [1:0]      exp_bis = 2'b00;
    logic [1:0]      exp_eis = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rising valid consumes one expected result
    initial begin : monitor
        logic            prev_valid;
        logic [c_CW-1:0] ea;
        logic [c_CW-1:0] ec;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && !prev_valid) begin
                if (exp_q_a.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid=1, expected no result pending");
                end else begin
                    ea = exp_q_a.pop_front();
                    ec = exp_q_c.pop_front();
                    chk("res_a", res_a, ea);
                    chk("res_c", res_c, ec);
                    chk("bis_at_valid", bis, exp_bis);
                    chk("eis_at_valid", eis, exp_eis);
                end
            end
            prev_valid = valid;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_brq"}, brq, 0);
        chk({tag, "_erq"}, erq, 0);
        chk({tag, "_bis"}, bis, 0);
        chk({tag, "_eis"}, eis, 0);
        chk({tag, "_res_a"}, res_a, 0);
        chk({tag, "_res_c"}, res_c, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Host issues start; setup inputs are scrambled afterwards so that only
    // latched values can explain later behaviour
    task automatic do_start(input logic [1:0] bs, input logic [1:0] es,
                            input logic [c_GW-1:0] g, input logic c);
        bsel  = bs;
        esel  = es;
        gate  = g;
        cont  = c;
        start = 1'b1;
        tick();
        start   = 1'b0;
        bsel    = 2'($urandom);
        esel    = 2'($urandom);
        gate    = $urandom;
        cont    = 1'($urandom);
        exp_bis = bs;
        exp_eis = es;
        chk("start_brq", brq, 1);
        chk("start_busy", busy, 1);
        chk("start_err", err, 0);
        chk("start_bis", bis, bs);
        chk("start_eis", eis, es);
    endtask

    // Counter-core side of one measurement, starting with brq already high
    task automatic meas(input logic [c_GW-1:0] g, input int dbac, input int deac,
                        input logic [c_CW-1:0] va, input logic [c_CW-1:0] vc,
                        input logic poke);
        int          n;
        longint      glen;
        glen = (g == 0) ? 1 : longint'(g);
        repeat (dbac) tick();
        bac = 1'b1;
        n   = 0;
        do begin
            start = poke && (n == 1);
            if (poke && (n == 1)) bsel = ~exp_bis;
            tick();
            n++;
        end while (!erq && n < 400);
        start = 1'b0;
        chk("gate_len", 64'(n), 64'(glen + 1));
        chk("stop_brq", brq, 1);
        repeat (deac) tick();
        eac = 1'b1;
        cta = va;
        ctc = vc;
        exp_q_a.push_back(va);
        exp_q_c.push_back(vc);
        last_a = va;
        last_c = vc;
        tick();
        cta = $urandom;
        ctc = $urandom;
        chk("rels_brq", brq, 0);
        chk("rels_erq", erq, 0);
        repeat ($urandom_range(0, 3)) tick();
        bac = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        chk("valid_early", valid, 0);
        eac = 1'b0;
        tick();
        chk("valid_rise", valid, 1);
        chk("done_busy", busy, 1);
    endtask

    task automatic do_ack(input logic c);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_valid", valid, 0);
        chk("ack_brq", brq, c);
        chk("ack_busy", busy, c);
    endtask

    initial begin : stim
        int n;
        logic [c_GW-1:0] g;
        logic [1:0]      bs;
        logic [1:0]      es;

        rst = 1'b1;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Reference single shot
        do_start(2'd1, 2'd2, 100, 1'b0);
        meas(100, 3, 5, 32'h1234, 32'hABCD, 1'b0);
        repeat (3) tick();
        chk("valid_hold", valid, 1);
        do_ack(1'b0);

        // Gate boundary values, with a stray start during GATE
        do_start(2'd2, 2'd3, 0, 1'b0);
        meas(0, 1, 2, $urandom, $urandom, 1'b0);
        do_ack(1'b0);
        do_start(2'd3, 2'd0, 1, 1'b0);
        meas(1, 2, 1, $urandom, $urandom, 1'b1);
        do_ack(1'b0);
        do_start(2'd0, 2'd1, 9, 1'b0);
        meas(9, 0, 0, $urandom, $urandom, 1'b1);
        do_ack(1'b0);

        // Randomised single shots
        for (int i = 0; i < 8; i++) begin
            g  = $urandom_range(0, 20);
            bs = 2'($urandom);
            es = 2'($urandom);
            do_start(bs, es, g, 1'b0);
            meas(g, $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom,
                 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
            do_ack(1'b0);
        end

        // Continuous mode, abort during the third gate window
        do_start(2'd1, 2'd3, 7, 1'b1);
        meas(7, 2, 3, $urandom, $urandom, 1'b0);
        do_ack(1'b1);
        chk("cont_bis", bis, 1);
        chk("cont_eis", eis, 3);
        meas(7, 1, 4, $urandom, $urandom, 1'b0);
        do_ack(1'b1);
        repeat (2) tick();
        bac = 1'b1;
        repeat (4) tick();
        chk("gate3_brq", brq, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_brq", brq, 0);
        chk("abort_erq", erq, 0);
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_res_a", res_a, last_a);
        chk("abort_res_c", res_c, last_c);
        bac = 1'b0;
        tick();

        // Begin-acknowledge timeout
        do_start(2'd2, 2'd1, 5, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (brq && n < 100);
        chk("tmo_len", n, 15);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_valid", valid, 0);
        chk("tmo_res_a", res_a, last_a);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("err_sticky", err, 1);
        do_start(2'd3, 2'd3, 5, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", busy, 0);

        // abort and ack together in DONE
        do_start(2'd0, 2'd1, 3, 1'b1);
        meas(3, 1, 1, $urandom, $urandom, 1'b0);
        abort = 1'b1;
        ack   = 1'b1;
        tick();
        abort = 1'b0;
        ack   = 1'b0;
        chk("coll_busy", busy, 0);
        chk("coll_brq", brq, 0);
        chk("coll_valid", valid, 0);
        tick();
        chk("coll_brq_later", brq, 0);

        // Reset while waiting in STOP
        do_start(2'd1, 2'd1, 4, 1'b0);
        tick();
        bac = 1'b1;
        n   = 0;
        do begin
            tick();
            n++;
        end while (!erq && n < 100);
        chk("pre_rst_erq", erq, 1);
        rst = 1'b1;
        tick();
        chk_reset_vals("midstop_rst");
        rst = 1'b0;
        bac = 1'b0;
        last_a = '0;
        last_c = '0;
        repeat (2) tick();

        chk("scoreboard_empty", 64'(exp_q_a.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fc_seq
`default_nettype wire
